// File: rtl/spr_bus_if.sv
// SPR bus signal bundle between the mor1kx SPR master and its slaves.
// The monitor modport observes every signal without driving any.
interface spr_bus_if #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int NUM_SLAVES           = 4
);
  logic [15:0]                     spr_bus_addr_o;
  logic                            spr_bus_we_o;
  logic                            spr_bus_stb_o;
  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o;
  logic [NUM_SLAVES-1:0]           spr_bus_ack_i;

  modport master (
    output spr_bus_addr_o, spr_bus_we_o, spr_bus_stb_o, spr_bus_dat_o,
    input  spr_bus_ack_i
  );

  modport slave (
    input  spr_bus_addr_o, spr_bus_we_o, spr_bus_stb_o, spr_bus_dat_o,
    output spr_bus_ack_i
  );

  modport monitor (
    input spr_bus_addr_o, spr_bus_we_o, spr_bus_stb_o, spr_bus_dat_o,
    input spr_bus_ack_i
  );
endinterface

// File: rtl/spr_bus_monitor.sv
// SPR bus protocol monitor: counts requests/acks, checks strobe/address/data
// stability and ack legality, and raises sticky error flags plus a timeout.
module spr_bus_monitor #(
  parameter int                        OPTION_OPERAND_WIDTH = 32,
  parameter int                        NUM_SLAVES           = 4,
  parameter logic [5*NUM_SLAVES-1:0]   SLAVE_GROUPS         = {5'd4, 5'd3, 5'd2, 5'd1},
  parameter int                        CNT_WIDTH            = 5,
  parameter int                        TIMEOUT              = 16,
  parameter bit                        ONEHOT_CHECK         = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  spr_bus_if.monitor           bus,
  output logic [CNT_WIDTH-1:0] mon_nreqs_o,
  output logic [CNT_WIDTH-1:0] mon_nacks_o,
  output logic                 mon_busy_o,
  output logic [5:0]           mon_err_o,
  output logic [15:0]          mon_err_addr_o
);

  localparam int SELW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int WCW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t state, state_n;

  logic [15:0]                     addr_q;
  logic                            we_q;
  logic [OPTION_OPERAND_WIDTH-1:0] dat_q;
  logic [SELW-1:0]                 sel_q;
  logic [WCW-1:0]                  wait_cnt;
  logic [CNT_WIDTH-1:0]            nreqs, nacks, nreqs_n, nacks_n;
  logic [5:0]                      err, err_set;
  logic [15:0]                     err_addr;

  logic                  hit;
  logic [SELW-1:0]       sel_dec;
  logic [NUM_SLAVES-1:0] mask_dec, mask_q;
  logic                  accept, ack_evt, busy;

  // Group decode: lowest-numbered matching slave wins.
  always_comb begin
    hit     = 1'b0;
    sel_dec = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (!hit && (bus.spr_bus_addr_o[15:11] == SLAVE_GROUPS[5*k +: 5])) begin
        hit     = 1'b1;
        sel_dec = SELW'(k);
      end
    end
  end

  assign mask_dec = NUM_SLAVES'(1) << sel_dec;
  assign mask_q   = NUM_SLAVES'(1) << sel_q;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    ack_evt = 1'b0;
    err_set = '0;
    unique case (state)
      ST_IDLE: begin
        if (bus.spr_bus_stb_o && hit) begin
          accept = 1'b1;
          if ((bus.spr_bus_ack_i & mask_dec) != '0) begin
            ack_evt = 1'b1;
            state_n = ST_DONE;
          end else begin
            state_n = ST_WAIT;
          end
        end
        // The ack completing a zero-wait request is the only legal ack here.
        if ((bus.spr_bus_ack_i & ~(ack_evt ? mask_dec : '0)) != '0)
          err_set[2] = 1'b1;
      end
      ST_WAIT: begin
        if ((bus.spr_bus_ack_i & mask_q) != '0) begin
          ack_evt = 1'b1;
          state_n = ST_DONE;
        end else if (!bus.spr_bus_stb_o) begin
          err_set[5] = 1'b1;
          state_n    = ST_IDLE;
        end
        if ((bus.spr_bus_ack_i & ~mask_q) != '0)
          err_set[3] = 1'b1;
        if (bus.spr_bus_stb_o &&
            ((bus.spr_bus_addr_o != addr_q) || (bus.spr_bus_we_o != we_q)))
          err_set[0] = 1'b1;
        if (bus.spr_bus_stb_o && we_q && (bus.spr_bus_dat_o != dat_q))
          err_set[1] = 1'b1;
        if ((wait_cnt == WAIT_LAST) && ((bus.spr_bus_ack_i & mask_q) == '0))
          err_set[4] = 1'b1;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    if (ONEHOT_CHECK && ($countones(bus.spr_bus_ack_i) > 1))
      err_set[3] = 1'b1;
  end

  always_comb begin
    busy = (state == ST_WAIT);
  end

  // nacks is bounded by the post-update nreqs so saturation never inverts them.
  assign nreqs_n = (accept && (nreqs != '1)) ? nreqs + 1'b1 : nreqs;
  assign nacks_n = (ack_evt && (nacks < nreqs_n)) ? nacks + 1'b1 : nacks;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      dat_q    <= '0;
      sel_q    <= '0;
      wait_cnt <= '0;
      nreqs    <= '0;
      nacks    <= '0;
      err      <= '0;
      err_addr <= '0;
    end else begin
      if (accept) begin
        addr_q <= bus.spr_bus_addr_o;
        we_q   <= bus.spr_bus_we_o;
        dat_q  <= bus.spr_bus_dat_o;
        sel_q  <= sel_dec;
      end
      if (accept)
        wait_cnt <= '0;
      else if ((state == ST_WAIT) && (wait_cnt != WAIT_LAST))
        wait_cnt <= wait_cnt + 1'b1;
      nreqs <= nreqs_n;
      nacks <= nacks_n;
      err   <= err | err_set;
      if ((err == '0) && (err_set != '0))
        err_addr <= (state == ST_IDLE) ? bus.spr_bus_addr_o : addr_q;
    end
  end

  assign mon_nreqs_o    = nreqs;
  assign mon_nacks_o    = nacks;
  assign mon_busy_o     = busy;
  assign mon_err_o      = err;
  assign mon_err_addr_o = err_addr;

endmodule
